// File: rtl/router_pkg.sv
// Shared mesh-router definitions: flit width, FIFO depth and output-port indices
// used by the input buffer, routing logic and output arbiters.
package router_pkg;

    localparam int unsigned FLIT_WIDTH = 32;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned NUM_PORTS  = 5;

    // Bit positions of each output port inside a grant/request vector
    localparam int unsigned PORT_N = 0;
    localparam int unsigned PORT_E = 1;
    localparam int unsigned PORT_W = 2;
    localparam int unsigned PORT_S = 3;
    localparam int unsigned PORT_L = 4;

    typedef logic [NUM_PORTS-1:0] grant_t;

    // True when two or more grant bits are set (clearing the lowest set bit leaves a residue)
    function automatic logic multi_grant(input grant_t g);
        return (g & (g - grant_t'(1))) != '0;
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Flit storage for the router input buffer: DEPTH x DATA_WIDTH registers,
// one synchronous write port and one asynchronous read port.
module router_fifo_mem #(
    parameter int unsigned DATA_WIDTH = router_pkg::FLIT_WIDTH,
    parameter int unsigned DEPTH      = router_pkg::FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]      rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/router_input_fifo.sv
// Per-port input buffer of the mesh router: RTS/CTS flit intake, FIFO storage, head flit
// to routing/arbiters. Optional multi-grant checker built when ROUTER_FIFO_GRANT_CHECK_EN is defined.
module router_input_fifo
    import router_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FLIT_WIDTH,
    parameter int unsigned DEPTH      = FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] RX,
    input  logic                  DRTS,
    input  logic                  read_en_N,
    input  logic                  read_en_E,
    input  logic                  read_en_W,
    input  logic                  read_en_S,
    input  logic                  read_en_L,
    output logic                  CTS,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  err_multi_grant
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    grant_t             grants;
    logic               accept;
    logic               pop;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_nxt;

    assign grants = {read_en_L, read_en_S, read_en_W, read_en_E, read_en_N};

    // CTS and full are registered, so a request seen during the CTS cycle is never re-accepted
    always_comb begin
        accept    = DRTS & ~CTS & ~full;
        pop       = (|grants) & ~empty;
        count_nxt = count_q;
        if (accept && !pop) begin
            count_nxt = count_q + CNT_W'(1);
        end else if (pop && !accept) begin
            count_nxt = count_q - CNT_W'(1);
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            CTS      <= 1'b0;
            empty    <= 1'b1;
            full     <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_nxt;
            CTS     <= accept;
            empty   <= (count_nxt == '0);
            full    <= (count_nxt == CNT_W'(DEPTH));
        end
    end

    router_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (accept),
        .waddr (wr_ptr_q),
        .wdata (RX),
        .raddr (rd_ptr_q),
        .rdata (Data_out)
    );

`ifdef ROUTER_FIFO_GRANT_CHECK_EN
    // Sticky until reset; the pop itself still happens only once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_multi_grant <= 1'b0;
        end else if (multi_grant(grants)) begin
            err_multi_grant <= 1'b1;
        end
    end
`else
    assign err_multi_grant = 1'b0;
`endif

endmodule

// File: tb/tb_router_input_fifo.sv
// Scoreboard bench for router_input_fifo: queue-based reference model pushes expected
// outputs each clock; a negedge monitor pops and compares.
module tb_router_input_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic          cts;
        logic          empty;
        logic          full;
        logic          err;
        logic          head_valid;
        logic [DW-1:0] head;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [DW-1:0] rx;
    logic          drts;
    logic          ren_n, ren_e, ren_w, ren_s, ren_l;
    logic          cts;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
    logic          err_multi_grant;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_q [$];
    logic          m_cts;
    logic          m_err;
    exp_t          exp_q [$];

    router_input_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .RX              (rx),
        .DRTS            (drts),
        .read_en_N       (ren_n),
        .read_en_E       (ren_e),
        .read_en_W       (ren_w),
        .read_en_S       (ren_s),
        .read_en_L       (ren_l),
        .CTS             (cts),
        .Data_out        (data_out),
        .empty           (empty),
        .full            (full),
        .err_multi_grant (err_multi_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: handshake and FIFO rules applied to a plain queue
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q.delete();
            exp_q.delete();
            m_cts = 1'b0;
            m_err = 1'b0;
        end else begin
            automatic logic [4:0] g = {ren_l, ren_s, ren_w, ren_e, ren_n};
            automatic int  sz  = model_q.size();
            automatic bit  acc = drts && !m_cts && (sz < int'(DEPTH));
            automatic bit  pp  = (g != 5'b0) && (sz > 0);
            automatic exp_t e;
`ifdef ROUTER_FIFO_GRANT_CHECK_EN
            if ($countones(g) > 1) m_err = 1'b1;
`endif
            if (pp) void'(model_q.pop_front());
            if (acc) model_q.push_back(rx);
            m_cts        = acc;
            e.cts        = m_cts;
            e.empty      = (model_q.size() == 0);
            e.full       = (model_q.size() == int'(DEPTH));
            e.err        = m_err;
            e.head_valid = (model_q.size() > 0);
            e.head       = (model_q.size() > 0) ? model_q[0] : '0;
            exp_q.push_back(e);
        end
    end

    // Monitor: compares DUT outputs against the oldest expected record
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_cts",   DW'(cts),             DW'(0));
            chk("rst_empty", DW'(empty),           DW'(1));
            chk("rst_full",  DW'(full),            DW'(0));
            chk("rst_data",  data_out,             DW'(0));
            chk("rst_err",   DW'(err_multi_grant), DW'(0));
        end else if (exp_q.size() > 0) begin
            automatic exp_t e = exp_q.pop_front();
            chk("cts",   DW'(cts),             DW'(e.cts));
            chk("empty", DW'(empty),           DW'(e.empty));
            chk("full",  DW'(full),            DW'(e.full));
            chk("err",   DW'(err_multi_grant), DW'(e.err));
            if (e.head_valid) chk("data_out", data_out, e.head);
        end
    end

    task automatic set_grants(input logic [4:0] g);
        {ren_l, ren_s, ren_w, ren_e, ren_n} = g;
    endtask

    // Hold RTS with stable RX until CTS is observed, then drop it
    task automatic send_flit(input logic [DW-1:0] d);
        automatic bit seen = 1'b0;
        drts = 1'b1;
        rx   = d;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (cts) begin
                seen = 1'b1;
                break;
            end
        end
        drts = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL cts_timeout flit %h: got no CTS expected CTS within 60 cycles", d);
        end
    endtask

    task automatic grant_cycle(input logic [4:0] g);
        set_grants(g);
        @(posedge clk); #1;
        set_grants(5'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst  = 1'b1;
        rx   = '0;
        drts = 1'b0;
        set_grants(5'b0);
        #23 rst = 1'b0;
        idle(10);

        // Single flit then one pop on E
        send_flit(32'hA5A5_0001);
        chk("single_data", data_out, 32'hA5A5_0001);
        chk("single_empty", DW'(empty), DW'(0));
        idle(1);
        grant_cycle(5'b00010);
        chk("single_drained", DW'(empty), DW'(1));

        // Fill to full, fifth flit waits for a pop on N, then drain with wrap-around
        for (int i = 1; i <= 4; i++) send_flit(DW'(i));
        chk("fill_full", DW'(full), DW'(1));
        chk("fill_head", data_out, DW'(1));
        fork
            send_flit(DW'(5));
            begin
                idle(4);
                chk("full_blocks_cts", DW'(cts), DW'(0));
                grant_cycle(5'b00001);
            end
        join
        for (int i = 2; i <= 5; i++) begin
            chk("wrap_order", data_out, DW'(i));
            grant_cycle(5'b00100);
        end
        chk("wrap_empty", DW'(empty), DW'(1));

        // Simultaneous accept and pop with two entries stored
        send_flit(32'hB0);
        send_flit(32'hB1);
        idle(1);
        fork
            send_flit(32'hB2);
            begin
                set_grants(5'b01000);
                @(posedge clk); #1;
                set_grants(5'b0);
            end
        join
        chk("same_cycle_head", data_out, 32'hB1);
        grant_cycle(5'b10000);
        grant_cycle(5'b10000);
        chk("same_cycle_empty", DW'(empty), DW'(1));

        // Asynchronous reset mid-cycle with three flits stored and CTS high
        send_flit(32'hC0);
        send_flit(32'hC1);
        send_flit(32'hC2);
        chk("pre_rst_cts", DW'(cts), DW'(1));
        #2 rst = 1'b1;
        #1;
        chk("async_rst_cts",   DW'(cts),   DW'(0));
        chk("async_rst_empty", DW'(empty), DW'(1));
        chk("async_rst_data",  data_out,   DW'(0));
        #6 rst = 1'b0;
        idle(2);

        // Randomized traffic: upstream and arbiter grants run independently
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    idle($urandom_range(0, 3));
                    send_flit($urandom);
                end
            end
            begin
                for (int c = 0; c < 1500; c++) begin
                    automatic int r = $urandom_range(0, 9);
                    if (r < 4) set_grants(5'b00001 << $urandom_range(0, 4));
                    else set_grants(5'b0);
                    @(posedge clk); #1;
                end
                set_grants(5'b0);
            end
        join
        while (!empty) grant_cycle(5'b00001);

        // Two grants in one cycle: exactly one pop, error flag per build option
        send_flit(32'hD0);
        send_flit(32'hD1);
        grant_cycle(5'b01001);
        chk("multi_grant_one_pop", data_out, 32'hD1);
        idle(1);
`ifdef ROUTER_FIFO_GRANT_CHECK_EN
        chk("multi_grant_err", DW'(err_multi_grant), DW'(1));
`else
        chk("multi_grant_err", DW'(err_multi_grant), DW'(0));
`endif
        grant_cycle(5'b00001);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
